proximity_input_conditioner: RTL

- Upstream stage for the robot rotation controller. It conditions the raw, asynchronous proximity-sensor pin into a clean, debounced level `z`, which drives the controller's `Z` input directly.
- Provides a multi-flop synchronizer, a symmetric debounce state machine, one-cycle edge strobes, and a saturating glitch counter for diagnostics.

---
 rtl/proximity_pkg.sv | 23 ++
 rtl/proximity_sync.sv | 26 ++
 rtl/proximity_input_conditioner.sv | 130 +++++++++++++
 3 files changed

// File: rtl/proximity_pkg.sv
// Shared types and defaults for the proximity sensor input conditioner.
// Contents: FSM state enum, default parameter values, debounce counter width helper.
package proximity_pkg;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    QUAL_SET = 2'd1,
    DETECT   = 2'd2,
    QUAL_CLR = 2'd3
  } prox_state_e;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 8;
  localparam int unsigned GLITCH_W_DEF        = 8;

  // ceil(log2(n)), floored at one bit so the counter always exists.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/proximity_sync.sv
// Multi-flop synchronizer for the asynchronous proximity pin.
// Ports: clk, rst_n (async active-low), d (raw async input), s (synchronized output).
module proximity_sync
  import proximity_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/proximity_input_conditioner.sv
// Conditions the raw proximity pin into a debounced level z for the rotation controller.
// Ports: clk, rst_n (async active-low), sensor_raw (async pin), glitch_clr (sync clear),
//        z (debounced level), z_rise/z_fall (one-cycle edge strobes),
//        glitch_cnt (saturating count of aborted qualifications).
module proximity_input_conditioner
  import proximity_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned GLITCH_W        = GLITCH_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sensor_raw,
  input  logic                glitch_clr,
  output logic                z,
  output logic                z_rise,
  output logic                z_fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s;
  prox_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_d, rise_d, fall_d;
  logic          glitch;

  proximity_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sensor_raw),
    .s    (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      z       <= 1'b0;
      z_rise  <= 1'b0;
      z_fall  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z       <= z_d;
      z_rise  <= rise_d;
      z_fall  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    glitch  = 1'b0;
    case (state_q)
      CLEAR: begin
        z_d = 1'b0;
        if (s) begin
          state_d = QUAL_SET;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_SET: begin
        if (s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = DETECT;
            cnt_d   = '0;
            z_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = CLEAR;
          cnt_d   = '0;
          glitch  = 1'b1;
        end
      end
      DETECT: begin
        z_d = 1'b1;
        if (!s) begin
          state_d = QUAL_CLR;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_CLR: begin
        if (!s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = CLEAR;
            cnt_d   = '0;
            z_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = DETECT;
          cnt_d   = '0;
          glitch  = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
        z_d     = 1'b0;
      end
    endcase
  end

  // Clear has priority over a same-edge glitch event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + {{(GLITCH_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
